// File: rtl/reg_file_mp_pkg.sv
// ============================================================================
// Module   : reg_file_mp_pkg
// Brief    : Shared defaults and helpers for the multi-port register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_file_mp_pkg;

    localparam int C_DEF_XLEN  = 32;
    localparam int C_DEF_NREG  = 32;
    localparam int C_ZERO_ADDR = 0;

    // The long-latency write port is always the last one.
    function automatic int ll_port(input int nwr);
        return nwr - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module   : reg_scoreboard
// Brief    : Per-register busy bits for pending LL results plus WAW error flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard
    import reg_file_mp_pkg::*;
#(
    parameter int NREG     = C_DEF_NREG,
    parameter int AW       = $clog2(NREG),
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NRD*AW-1:0] rd_addr_i,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    input  logic              rsv_en_i,
    input  logic [AW-1:0]     rsv_addr_i,
    output logic [NRD-1:0]    rd_busy_o,
    output logic              waw_err_o
);

    localparam int C_LL = ll_port(NWR);

    logic [NREG-1:0] busy_q, busy_d;
    logic            w_ll_wr;
    logic [AW-1:0]   w_ll_addr;
    logic            w_rsv_ok;

    assign w_ll_wr   = wr_en_i[C_LL];
    assign w_ll_addr = wr_addr_i[C_LL*AW +: AW];
    assign w_rsv_ok  = rsv_en_i && !(ZERO_REG != 0 && rsv_addr_i == AW'(C_ZERO_ADDR));

    // A reservation on the same edge as the LL retire wins: a new LL op was issued.
    always_comb begin
        busy_d = busy_q;
        if (w_ll_wr)
            busy_d[w_ll_addr] = 1'b0;
        if (w_rsv_ok)
            busy_d[rsv_addr_i] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd_busy
        logic [AW-1:0] w_a;
        assign w_a          = rd_addr_i[k*AW +: AW];
        assign rd_busy_o[k] = busy_q[w_a] & ~(w_ll_wr && (w_ll_addr == w_a));
    end

    if (NWR > 1) begin : g_waw
        logic waw_q, waw_d;

        always_comb begin
            waw_d = 1'b0;
            for (int j = 0; j < NWR - 1; j++)
                if (wr_en_i[j] && busy_q[wr_addr_i[j*AW +: AW]])
                    waw_d = 1'b1;
        end

        always_ff @(posedge clk_i) begin
            if (rst_i)
                waw_q <= 1'b0;
            else
                waw_q <= waw_d;
        end

        assign waw_err_o = waw_q;
    end else begin : g_no_waw
        assign waw_err_o = 1'b0;
    end

endmodule

`default_nettype wire

// File: rtl/reg_file_mp.sv
// ============================================================================
// Module   : reg_file_mp
// Brief    : N-read / M-write register file with write bypass and LL scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int XLEN     = C_DEF_XLEN,
    parameter int NREG     = C_DEF_NREG,
    parameter int AW       = $clog2(NREG),
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                ip_clk,
    input  logic                ip_rst,
    input  logic [NRD*AW-1:0]   ip_rd_addr,
    output logic [NRD*XLEN-1:0] op_rd_data,
    output logic [NRD-1:0]      op_rd_busy,
    input  logic [NWR-1:0]      ip_wr_en,
    input  logic [NWR*AW-1:0]   ip_wr_addr,
    input  logic [NWR*XLEN-1:0] ip_wr_data,
    input  logic                ip_rsv_en,
    input  logic [AW-1:0]       ip_rsv_addr,
    output logic                op_waw_err
);

    logic [XLEN-1:0] regs_q [NREG];

    function automatic logic is_hard_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == AW'(C_ZERO_ADDR));
    endfunction

    // Ascending port order makes the highest-numbered port win on collisions.
    always_ff @(posedge ip_clk) begin
        if (ip_rst) begin
            for (int r = 0; r < NREG; r++)
                regs_q[r] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++)
                if (ip_wr_en[j] && !is_hard_zero(ip_wr_addr[j*AW +: AW]))
                    regs_q[ip_wr_addr[j*AW +: AW]] <= ip_wr_data[j*XLEN +: XLEN];
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_a;
        logic [XLEN-1:0] w_data;

        assign w_a = ip_rd_addr[k*AW +: AW];

        always_comb begin
            w_data = is_hard_zero(w_a) ? '0 : regs_q[w_a];
            for (int j = 0; j < NWR; j++)
                if (ip_wr_en[j] && (ip_wr_addr[j*AW +: AW] == w_a) && !is_hard_zero(w_a))
                    w_data = ip_wr_data[j*XLEN +: XLEN];
        end

        assign op_rd_data[k*XLEN +: XLEN] = w_data;
    end

    reg_scoreboard #(
        .NREG     (NREG),
        .AW       (AW),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i      (ip_clk),
        .rst_i      (ip_rst),
        .rd_addr_i  (ip_rd_addr),
        .wr_en_i    (ip_wr_en),
        .wr_addr_i  (ip_wr_addr),
        .rsv_en_i   (ip_rsv_en),
        .rsv_addr_i (ip_rsv_addr),
        .rd_busy_o  (op_rd_busy),
        .waw_err_o  (op_waw_err)
    );

endmodule

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
// ============================================================================
// Module   : tb_reg_file_mp
// Brief    : Directed self-checking bench for reg_file_mp (2R/2W, x0 hardwired).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NWR  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                waw_err;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    reg_file_mp #(
        .XLEN(XLEN), .NREG(32), .AW(AW), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)
    ) dut (
        .ip_clk      (clk),
        .ip_rst      (rst),
        .ip_rd_addr  (rd_addr),
        .op_rd_data  (rd_data),
        .op_rd_busy  (rd_busy),
        .ip_wr_en    (wr_en),
        .ip_wr_addr  (wr_addr),
        .ip_wr_data  (wr_data),
        .ip_rsv_en   (rsv_en),
        .ip_rsv_addr (rsv_addr),
        .op_waw_err  (waw_err)
    );

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Next cycle: wait for the falling edge, drop all strobes.
    task automatic next();
        @(negedge clk);
        wr_en  = '0;
        rsv_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
        wr_en[port]              = 1'b1;
        wr_addr[port*AW +: AW]   = a;
        wr_data[port*XLEN +: 32] = d;
    endtask

    task automatic rsv(input logic [4:0] a);
        rsv_en   = 1'b1;
        rsv_addr = a;
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        repeat (2) @(posedge clk);
        next(); rst = 1'b0;

        // Reset state
        rd(5'd5, 5'd31); #1;
        push("rst_rd0", 32'h0); push("rst_rd1", 32'h0);
        push("rst_busy", 32'h0); push("rst_waw", 32'h0);
        check(rd_data[31:0]); check(rd_data[63:32]);
        check({30'h0, rd_busy}); check({31'h0, waw_err});

        // 1: plain write, read next cycle
        wr(0, 5'd5, 32'hDEADBEEF);
        next(); rd(5'd5, 5'd6); #1;
        push("t1_x5", 32'hDEADBEEF); push("t1_x6", 32'h0);
        check(rd_data[31:0]); check(rd_data[63:32]);

        // 2: x0 is hardwired, even against same-cycle bypass
        wr(0, 5'd0, 32'h12345678); rd(5'd0, 5'd0); #1;
        push("t2_x0_same", 32'h0);
        check(rd_data[31:0]);
        next(); #1;
        push("t2_x0_after", 32'h0);
        check(rd_data[63:32]);

        // 3: two ports hit x7, highest port wins in bypass and storage
        wr(0, 5'd7, 32'h1); wr(1, 5'd7, 32'h2); rd(5'd7, 5'd5); #1;
        push("t3_bypass", 32'h2); push("t3_other", 32'hDEADBEEF);
        check(rd_data[31:0]); check(rd_data[63:32]);
        next(); #1;
        push("t3_stored", 32'h2);
        check(rd_data[31:0]);

        // 4: reservation visible next cycle; LL write clears and bypasses
        rsv(5'd10); rd(5'd10, 5'd7); #1;
        push("t4_busy_same", 32'h0);
        check({30'h0, rd_busy});
        next(); #1;
        push("t4_busy_next", 32'h1);
        check({30'h0, rd_busy});
        wr(1, 5'd10, 32'h0000CAFE); #1;
        push("t4_ll_busy", 32'h0); push("t4_ll_bypass", 32'h0000CAFE);
        check({30'h0, rd_busy}); check(rd_data[31:0]);
        next(); #1;
        push("t4_busy_after", 32'h0); push("t4_data_after", 32'h0000CAFE);
        check({30'h0, rd_busy}); check(rd_data[31:0]);

        // 5: reserve + LL write same cycle -> busy stays; then WAW pulse
        rsv(5'd10); wr(1, 5'd10, 32'h0000BEEF); #1;
        push("t5_busy_same", 32'h0);
        check({30'h0, rd_busy});
        next(); #1;
        push("t5_busy_kept", 32'h1); push("t5_data", 32'h0000BEEF);
        check({30'h0, rd_busy}); check(rd_data[31:0]);
        wr(0, 5'd10, 32'h00001111); #1;
        push("t5_waw_before", 32'h0);
        check({31'h0, waw_err});
        next(); #1;
        push("t5_waw_pulse", 32'h1); push("t5_waw_data", 32'h00001111);
        push("t5_waw_busy", 32'h1);
        check({31'h0, waw_err}); check(rd_data[31:0]); check({30'h0, rd_busy});
        next(); #1;
        push("t5_waw_gone", 32'h0);
        check({31'h0, waw_err});

        // 6: reset mid-operation wipes data, busy and a pending WAW
        rsv(5'd3); wr(0, 5'd3, 32'h55); rd(5'd3, 5'd10);
        next(); #1;
        push("t6_pre_data", 32'h55); push("t6_pre_busy", 32'h3);
        check(rd_data[31:0]); check({30'h0, rd_busy});
        rst = 1'b1; wr(0, 5'd10, 32'h77); wr(1, 5'd5, 32'h99); rsv(5'd4);
        next(); rst = 1'b0; rd(5'd3, 5'd4); #1;
        push("t6_x3", 32'h0); push("t6_x4", 32'h0);
        push("t6_busy", 32'h0); push("t6_waw", 32'h0);
        check(rd_data[31:0]); check(rd_data[63:32]);
        check({30'h0, rd_busy}); check({31'h0, waw_err});
        rd(5'd10, 5'd5); #1;
        push("t6_x10", 32'h0); push("t6_x5", 32'h0);
        check(rd_data[31:0]); check(rd_data[63:32]);

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
